rm1_encoder_stream: RTL

RM1_ENCODER_STREAM -- requirements
Module: rm1_encoder_stream

---
 rtl/rm1_encoder_stream.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/rm1_encoder_stream.sv
// rm1_encoder_stream: first-order Reed-Muller encoder feeding a small codeword FIFO.
// Defining RM_ENC_SERIAL_EN replaces the parallel output with an LSB-first bit-serial stage.
module rm1_encoder_stream #(
   parameter  int M     = 4,
   parameter  int DEPTH = 2,
   localparam int K     = M + 1,
   localparam int N     = 1 << M,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [K-1:0]  in_msg,
   output logic          in_ready,
   output logic          out_valid,
   output logic [N-1:0]  out_cw,
   input  logic          out_ready,
   output logic [LW-1:0] level
`ifdef RM_ENC_SERIAL_EN
   ,
   output logic          ser_data,
   output logic          ser_valid,
   output logic          ser_last,
   input  logic          ser_ready
`endif
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

   // Bit j is the affine form msg[0] + sum(msg[i+1] * j[i]) over GF(2).
   function automatic logic [N-1:0] rm1_encode(input logic [K-1:0] msg);
      logic [N-1:0] cw;
      logic [M-1:0] idx;
      cw = '0;
      for (int j = 0; j < N; j++) begin
         idx   = M'(j);
         cw[j] = msg[0] ^ (^(msg[K-1:1] & idx));
      end
      return cw;
   endfunction

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
   endfunction

   logic [N-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          ready_en_q;
   logic [N-1:0]  enc_cw;
   logic [N-1:0]  head_cw;
   logic          push;
   logic          pop;
   logic          fifo_nempty;

   assign enc_cw      = rm1_encode(in_msg);
   assign fifo_nempty = (level_q != '0);
   // ready_en_q keeps in_ready low during reset and lifts it on the first edge after.
   assign in_ready    = ready_en_q && (level_q < DEPTH_L);
   assign push        = in_valid && in_ready;
   assign head_cw     = mem_q[rd_ptr_q];
   assign level       = level_q;

   // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
   always_comb begin
      wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      level_d  = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         ready_en_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         ready_en_q <= 1'b1;
      end
   end

   // NOTE: storage is not reset; pointers and level alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= enc_cw;
      end
   end

`ifdef RM_ENC_SERIAL_EN
   typedef enum logic {S_IDLE, S_SHIFT} ser_state_e;

   localparam logic [M-1:0] LAST_BIT = M'(N - 1);

   ser_state_e   state_q, state_d;
   logic [N-1:0] sh_q, sh_d;
   logic [M-1:0] cnt_q, cnt_d;
   logic         ser_pop;
   logic         unused_out_ready;

   assign unused_out_ready = out_ready;
   assign pop              = ser_pop;
   assign out_valid        = 1'b0;
   assign out_cw           = head_cw;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sh_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
      end
   end

   // Finishing a word while the FIFO holds another reloads directly, keeping the stream gapless.
   always_comb begin
      state_d = state_q;
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      ser_pop = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fifo_nempty) begin
               ser_pop = 1'b1;
               sh_d    = head_cw;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (ser_ready) begin
               if (cnt_q == LAST_BIT) begin
                  cnt_d = '0;
                  if (fifo_nempty) begin
                     ser_pop = 1'b1;
                     sh_d    = head_cw;
                     state_d = S_SHIFT;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ser_valid = (state_q == S_SHIFT);
      ser_data  = sh_q[cnt_q];
      ser_last  = (state_q == S_SHIFT) && (cnt_q == LAST_BIT);
   end
`else
   assign out_valid = fifo_nempty;
   assign out_cw    = head_cw;
   assign pop       = out_valid && out_ready;
`endif

endmodule
